// File: rtl/multi_dataflow_tcdm_arbiter.sv
// Round-robin arbiter sharing one TCDM master port among NR requester channels.
// An ID FIFO records the owner of each outstanding transaction so in-order responses route back.
module multi_dataflow_tcdm_arbiter #(
    parameter int unsigned NR        = 4,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    // requester side
    input  logic [NR-1:0]                in_req,
    output logic [NR-1:0]                in_gnt,
    input  logic [NR-1:0][AW-1:0]        in_add,
    input  logic [NR-1:0]                in_wen,
    input  logic [NR-1:0][DW/8-1:0]      in_be,
    input  logic [NR-1:0][DW-1:0]        in_data,
    output logic [NR-1:0][DW-1:0]        in_r_data,
    output logic [NR-1:0]                in_r_valid,
    // shared TCDM port
    output logic                         tcdm_req,
    input  logic                         tcdm_gnt,
    output logic [AW-1:0]                tcdm_add,
    output logic                         tcdm_wen,
    output logic [DW/8-1:0]              tcdm_be,
    output logic [DW-1:0]                tcdm_data,
    input  logic [DW-1:0]                tcdm_r_data,
    input  logic                         tcdm_r_valid,
    // status
    output logic                         busy_o,
    output logic                         err_o
);

    localparam int unsigned IDW = (NR > 1) ? $clog2(NR) : 1;
    localparam int unsigned PW  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned CW  = $clog2(MAX_OUTST + 1);

    logic [IDW-1:0]                 rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]                 winner;
    logic [MAX_OUTST-1:0][IDW-1:0]  fifo_q;
    logic [PW-1:0]                  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                  count_q, count_d;
    logic                           err_q, err_d;
    logic                           any_req, full, accept, pop, spurious;
    logic [IDW-1:0]                 head_id;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    // Scan from the highest offset down so the closest requester to rr_ptr wins last.
    always_comb begin
        int idx;
        winner = '0;
        idx    = 0;
        for (int k = int'(NR) - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= int'(NR)) begin
                idx = idx - int'(NR);
            end
            if (in_req[IDW'(idx)]) begin
                winner = IDW'(idx);
            end
        end
    end

    assign any_req  = |in_req;
    assign full     = (count_q == CW'(MAX_OUTST));
    assign tcdm_req = any_req & ~full;
    assign accept   = tcdm_req & tcdm_gnt;
    assign pop      = tcdm_r_valid & (count_q != '0);
    assign spurious = tcdm_r_valid & (count_q == '0);
    assign head_id  = fifo_q[rd_ptr_q];

    // Request fields are forced to zero while no request is presented.
    always_comb begin
        tcdm_add  = '0;
        tcdm_wen  = 1'b0;
        tcdm_be   = '0;
        tcdm_data = '0;
        if (tcdm_req) begin
            tcdm_add  = in_add[winner];
            tcdm_wen  = in_wen[winner];
            tcdm_be   = in_be[winner];
            tcdm_data = in_data[winner];
        end
    end

    always_comb begin
        in_gnt = '0;
        if (accept) begin
            in_gnt[winner] = 1'b1;
        end
    end

    always_comb begin
        in_r_valid = '0;
        if (pop) begin
            in_r_valid[head_id] = 1'b1;
        end
        for (int i = 0; i < int'(NR); i++) begin
            in_r_data[i] = tcdm_r_data;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (winner == IDW'(NR - 1)) ? '0 : winner + 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        unique case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        err_d = err_q | spurious;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else if (clear_i) begin
            rr_ptr_q <= '0;
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
            if (accept) begin
                fifo_q[wr_ptr_q] <= winner;
            end
        end
    end

    assign busy_o = (count_q != '0);
    assign err_o  = err_q;

endmodule
